// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the per-size alignment rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Illegal size or a lane offset that does not match the access width.
  function automatic logic size_fault(size_e size, logic [1:0] lane);
    logic bad;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering for the data memory: store lane enables and data
// replication, load lane selection with sign or zero extension.
module dmem_align
  import dmem_pkg::*;
(
  input  size_e       size_i,
  input  logic        is_signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  lane_en_o,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = ld_word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  always_comb begin
    lane_en_o = 4'b0000;
    st_word_o = st_data_i;
    ld_data_o = ld_word_i;
    unique case (size_i)
      SZ_BYTE: begin
        lane_en_o = 4'b0001 << lane_i;
        st_word_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{is_signed_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        lane_en_o = lane_i[1] ? 4'b1100 : 4'b0011;
        st_word_o = {2{st_data_i[15:0]}};
        ld_data_o = {{16{is_signed_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        // Word loads ignore is_signed_i.
        lane_en_o = 4'b1111;
      end
      SZ_ILL: begin
        lane_en_o = 4'b0000;
      end
      default: begin
        lane_en_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with byte/halfword/word access, fixed load latency of
// one cycle and fault pulses. Define DMEM_CLEAR_EN to zero the RAM after reset.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        W_En,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] W_Data,
  output logic        Ready,
  output logic        R_Valid,
  output logic [31:0] R_Data,
  output logic        Fault
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef DMEM_CLEAR_EN
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
`endif

  logic [31:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_we;

  logic          r_valid_q;
  logic          fault_q;
  logic [31:0]   r_data_q;

  size_e         size;
  logic          borrow;
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          range_fault;
  logic          access_fault;
  logic          accept;
  logic          st_ok;
  logic          ld_ok;

  logic [3:0]    lane_en;
  logic [31:0]   st_word;
  logic [31:0]   ld_word;
  logic [31:0]   ld_ext;
  logic [31:0]   wr_word;

  assign size = size_e'(Size);

  // The borrow out of the subtraction flags addresses below the window.
  assign {borrow, offset} = {1'b0, Addr} - {1'b0, BASE_ADDR};
  assign range_fault      = borrow | (|offset[31:AW+2]);
  assign access_fault     = range_fault | size_fault(size, offset[1:0]);
  assign word_idx         = offset[AW+1:2];

  assign accept = Req & Ready;
  assign st_ok  = accept & W_En & ~access_fault;
  assign ld_ok  = accept & ~W_En & ~access_fault;

  assign ld_word = mem[word_idx];

  dmem_align u_align (
    .size_i      (size),
    .is_signed_i (Signed),
    .lane_i      (offset[1:0]),
    .st_data_i   (W_Data),
    .ld_word_i   (ld_word),
    .lane_en_o   (lane_en),
    .st_word_o   (st_word),
    .ld_data_o   (ld_ext)
  );

  // Read-modify-write merge so the array sees whole-word writes only.
  always_comb begin
    wr_word = ld_word;
    for (int k = 0; k < 4; k++) begin
      if (lane_en[k]) begin
        wr_word[8*k +: 8] = st_word[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      CLEAR: begin
`ifdef DMEM_CLEAR_EN
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      r_valid_q <= 1'b0;
      fault_q   <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      r_valid_q <= ld_ok;
      fault_q   <= accept & access_fault;
      if (ld_ok) begin
        r_data_q <= ld_ext;
      end
    end
  end

  // The array has no reset; Rst only blocks writes on its own edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (clr_we) begin
        mem[clr_cnt_q] <= '0;
      end else if (st_ok) begin
        mem[word_idx] <= wr_word;
      end
    end
  end

  assign Ready   = (state_q == RUN) & ~Rst;
  assign R_Valid = r_valid_q;
  assign Fault   = fault_q;
  assign R_Data  = r_data_q;

endmodule
